// File: rtl/button_conditioner_if.sv
// Pin-side bundle for the button conditioner: raw push-button levels in, clean pulses out.
// Latency: none (wires only).
// Backpressure: none; pulses are fire-and-forget.
//
// Signals:
//   mode_raw, add_raw, sub_raw          raw asynchronous button levels, 1 = pressed
//   mode_button, add_button, sub_button one-cycle pulses towards the clock interface FSM
// Modports:
//   slave  - the conditioner (consumes raw levels, drives pulses)
//   master - the board/stimulus side (drives raw levels, observes pulses)

interface button_conditioner_if;
  logic mode_raw;
  logic add_raw;
  logic sub_raw;
  logic mode_button;
  logic add_button;
  logic sub_button;

  modport slave (
    input  mode_raw,
    input  add_raw,
    input  sub_raw,
    output mode_button,
    output add_button,
    output sub_button
  );

  modport master (
    output mode_raw,
    output add_raw,
    output sub_raw,
    input  mode_button,
    input  add_button,
    input  sub_button
  );
endinterface

// File: rtl/button_conditioner.sv
// Synchronize, debounce and edge-detect the mode/add/sub buttons into single-cycle pulses.
// Latency: raw level first sampled at edge 0 -> pulse visible for one cycle after edge DEBOUNCE_CYCLES+2.
// Backpressure: none; pulses are emitted unconditionally and never queued.
//
// Ports:
//   clock  system clock (100 MHz nominal)
//   reset  synchronous, active-high; clears every flop, outputs held low while asserted
//   bus    button_conditioner_if.slave: raw button levels in, mode/add/sub pulses out
// Parameters:
//   DEBOUNCE_CYCLES  consecutive cycles a changed level must persist before it is accepted (>= 2)
//   REPEAT_DELAY     cycles from the initial add/sub pulse to the first auto-repeat pulse
//   REPEAT_RATE      cycles between subsequent auto-repeat pulses
// Build option:
//   BUTTON_AUTO_REPEAT_EN  when defined, held add/sub buttons auto-repeat (IDLE/WAIT/REPEAT/BLOCKED);
//                          when undefined they give one pulse per press (IDLE/BLOCKED only).
// Channel index used throughout: 0 = mode, 1 = add, 2 = sub. The add/sub FSM arrays use 0 = add, 1 = sub.

module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_RATE     = 10_000_000
) (
  input  logic                 clock,
  input  logic                 reset,
  button_conditioner_if.slave  bus
);

  // Smaller values would let the debouncer or the repeat timer fire on back-to-back
  // cycles, breaking the "never two pulses on consecutive cycles" guarantee.
  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_RATE < 2) begin : g_param_check
    $error("button_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_RATE must all be >= 2");
  end

  // Debounce counter only ever needs to reach DEBOUNCE_CYCLES-1.
  localparam int             CW       = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BLOCKED = 2'd3;
`ifdef BUTTON_AUTO_REPEAT_EN
  localparam logic [1:0] WAIT    = 2'd1;
  localparam logic [1:0] REPEAT  = 2'd2;

  localparam int             TMAX       = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int             TW         = $clog2(TMAX + 1);
  localparam logic [TW-1:0]  DELAY_LAST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0]  RATE_LAST  = TW'(REPEAT_RATE - 1);
  localparam logic [TW-1:0]  TIMER_MAX  = '1;
`endif

  // ---------------------------------------------------------------------------
  // Synchronizer + debouncer, one lane per button
  // ---------------------------------------------------------------------------
  logic [2:0]     raw;
  logic [2:0]     s1;
  logic [2:0]     s2;
  logic [2:0]     stable;
  logic [2:0]     press;    // one-cycle flag, set on the edge where stable goes 0->1
  logic [CW-1:0]  cnt [3];

  assign raw = {bus.sub_raw, bus.add_raw, bus.mode_raw};

  always_ff @(posedge clock) begin
    if (reset) begin
      s1     <= '0;
      s2     <= '0;
      stable <= '0;
      press  <= '0;
      for (int i = 0; i < 3; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < 3; i++) begin
        press[i] <= 1'b0;
        if (s2[i] == stable[i]) begin
          // Level agrees with the accepted one: any bounce restarts the window.
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          // Changed level held long enough; a release (s2 = 0) never flags a press.
          stable[i] <= s2[i];
          cnt[i]    <= '0;
          press[i]  <= s2[i];
        end else begin
          // Cannot pass CNT_LAST, so the counter never wraps.
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Add and sub held together (or pressed on the same edge) is ambiguous: suppress both.
  logic lock;
  assign lock = (stable[1] & stable[2]) | (press[1] & press[2]);

  // ---------------------------------------------------------------------------
  // Mode: plain one-shot, independent of the add/sub lockout
  // ---------------------------------------------------------------------------
  logic mode_pulse;

  always_ff @(posedge clock) begin
    if (reset) begin
      mode_pulse <= 1'b0;
    end else begin
      mode_pulse <= press[0];
    end
  end

  // ---------------------------------------------------------------------------
  // Add/sub pulse FSMs
  // ---------------------------------------------------------------------------
  logic [1:0] state [2];
  logic [1:0] pulse;

`ifdef BUTTON_AUTO_REPEAT_EN
  logic [TW-1:0] timer [2];

  always_ff @(posedge clock) begin
    if (reset) begin
      pulse <= '0;
      for (int i = 0; i < 2; i++) begin
        state[i] <= IDLE;
        timer[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        pulse[i] <= 1'b0;
        if (lock) begin
          state[i] <= BLOCKED;
          timer[i] <= '0;
        end else begin
          case (state[i])
            IDLE: begin
              if (press[i+1]) begin
                pulse[i] <= 1'b1;
                timer[i] <= '0;
                state[i] <= WAIT;
              end
            end
            WAIT: begin
              if (!stable[i+1]) begin
                // Released before the first repeat: drop back silently.
                timer[i] <= '0;
                state[i] <= IDLE;
              end else if (timer[i] == DELAY_LAST) begin
                pulse[i] <= 1'b1;
                timer[i] <= '0;
                state[i] <= REPEAT;
              end else if (timer[i] != TIMER_MAX) begin
                timer[i] <= timer[i] + TW'(1);
              end
            end
            REPEAT: begin
              if (!stable[i+1]) begin
                timer[i] <= '0;
                state[i] <= IDLE;
              end else if (timer[i] == RATE_LAST) begin
                pulse[i] <= 1'b1;
                timer[i] <= '0;
              end else if (timer[i] != TIMER_MAX) begin
                timer[i] <= timer[i] + TW'(1);
              end
            end
            BLOCKED: begin
              // Each button must be let go on its own before it can fire again.
              if (!stable[i+1]) begin
                state[i] <= IDLE;
              end
            end
            default: begin
              timer[i] <= '0;
              state[i] <= IDLE;
            end
          endcase
        end
      end
    end
  end
`else
  always_ff @(posedge clock) begin
    if (reset) begin
      pulse <= '0;
      for (int i = 0; i < 2; i++) begin
        state[i] <= IDLE;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        pulse[i] <= 1'b0;
        if (lock) begin
          state[i] <= BLOCKED;
        end else begin
          case (state[i])
            IDLE: begin
              if (press[i+1]) begin
                pulse[i] <= 1'b1;
              end
            end
            BLOCKED: begin
              if (!stable[i+1]) begin
                state[i] <= IDLE;
              end
            end
            default: begin
              state[i] <= IDLE;
            end
          endcase
        end
      end
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Gating with reset keeps the pins low for the whole reset window, including the
  // cycle in which reset is first raised. Gating with lock kills a pulse that was
  // registered just before the second button became stable.
  assign bus.mode_button = mode_pulse & ~reset;
  assign bus.add_button  = pulse[0] & ~lock & ~reset;
  assign bus.sub_button  = pulse[1] & ~lock & ~reset;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with small debounce/repeat parameters.
// Expected pulse times are hand-derived: pulse at (first sampling edge) + DEBOUNCE_CYCLES + 2,
// repeats at +REPEAT_DELAY then every REPEAT_RATE while the debounced level stays high.

module tb_button_conditioner;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RR = 8;

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;

  button_conditioner_if bus ();

  button_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_RATE     (RR)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Edge counter: after posedge k, cyc == k.
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Pulse recorder, sampled on the falling edge.
  bit rec = 1'b0;
  int mode_q[$];
  int add_q[$];
  int sub_q[$];

  always @(negedge clock) begin
    if (rec) begin
      if (bus.mode_button) mode_q.push_back(cyc);
      if (bus.add_button)  add_q.push_back(cyc);
      if (bus.sub_button)  sub_q.push_back(cyc);
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: bus.mode_raw = v;
      1: bus.add_raw  = v;
      default: bus.sub_raw = v;
    endcase
  endtask

  task automatic clear_q();
    mode_q.delete();
    add_q.delete();
    sub_q.delete();
  endtask

  function automatic int adjacent(input int q[$]);
    int n = 0;
    for (int k = 1; k < q.size(); k++) begin
      if (q[k] == q[k-1] + 1) n++;
    end
    return n;
  endfunction

  typedef struct {
    string name;
    int    btn;    // 0 mode, 1 add, 2 sub
    int    hold;   // edges the raw level is sampled high
    int    n;      // expected pulse count
    int    first;  // first pulse, relative to first sampling edge (-1 = none)
    int    last;   // last pulse, relative to first sampling edge (-1 = none)
  } vec_t;

  vec_t vecs[6];

  initial begin
    int t0;
    int t1;
    int q[$];
    int others;
    int exp_q[$];

    vecs[0] = '{"clean_add",  1, 10, 1,            6,  6};
    vecs[1] = '{"add_hold",   1, 60, AR ? 6 : 1,   6,  AR ? 58 : 6};
    vecs[2] = '{"mode_hold",  0, 60, 1,            6,  6};
    vecs[3] = '{"sub_hold",   2, 30, AR ? 3 : 1,   6,  AR ? 34 : 6};
    vecs[4] = '{"add_min",    1,  4, 1,            6,  6};
    vecs[5] = '{"sub_glitch", 2,  3, 0,           -1, -1};

    bus.mode_raw = 1'b0;
    bus.add_raw  = 1'b0;
    bus.sub_raw  = 1'b0;

    // ---- reset state ----
    reset = 1'b1;
    tick(3);
    check("rst_mode", int'(bus.mode_button), 0);
    check("rst_add",  int'(bus.add_button),  0);
    check("rst_sub",  int'(bus.sub_button),  0);
    reset = 1'b0;
    tick(1);
    check("post_rst_mode", int'(bus.mode_button), 0);
    check("post_rst_add",  int'(bus.add_button),  0);
    check("post_rst_sub",  int'(bus.sub_button),  0);
    rec = 1'b1;
    tick(2);

    // ---- table-driven single-button presses ----
    for (int i = 0; i < 6; i++) begin
      clear_q();
      set_btn(vecs[i].btn, 1'b1);
      t0 = cyc + 1;
      tick(vecs[i].hold);
      set_btn(vecs[i].btn, 1'b0);
      tick(25);
      case (vecs[i].btn)
        0: begin q = mode_q; others = add_q.size() + sub_q.size();  end
        1: begin q = add_q;  others = mode_q.size() + sub_q.size(); end
        default: begin q = sub_q; others = mode_q.size() + add_q.size(); end
      endcase
      check({vecs[i].name, "_count"}, q.size(), vecs[i].n);
      check({vecs[i].name, "_first"}, (q.size() > 0) ? q[0] - t0 : -1, vecs[i].first);
      check({vecs[i].name, "_last"},  (q.size() > 0) ? q[q.size()-1] - t0 : -1, vecs[i].last);
      check({vecs[i].name, "_other"}, others, 0);
      check({vecs[i].name, "_adjacent"}, adjacent(q), 0);
    end

    // ---- bounce: mode toggles every 2 cycles, then settles high ----
    clear_q();
    t0 = cyc + 1;
    for (int k = 0; k < 12; k++) begin
      bus.mode_raw = ((k / 2) % 2) == 0;
      tick(1);
    end
    bus.mode_raw = 1'b1;
    tick(20);
    bus.mode_raw = 1'b0;
    tick(20);
    check("bounce_count", mode_q.size(), 1);
    check("bounce_time", (mode_q.size() > 0) ? mode_q[0] - t0 : -1, 18);

    // ---- add+sub+mode pressed on the same edge: add/sub locked out, mode fires ----
    clear_q();
    bus.mode_raw = 1'b1;
    bus.add_raw  = 1'b1;
    bus.sub_raw  = 1'b1;
    t0 = cyc + 1;
    tick(10);
    bus.mode_raw = 1'b0;
    bus.add_raw  = 1'b0;
    bus.sub_raw  = 1'b0;
    tick(20);
    check("tri_mode_count", mode_q.size(), 1);
    check("tri_mode_time", (mode_q.size() > 0) ? mode_q[0] - t0 : -1, 6);
    check("tri_add_count", add_q.size(), 0);
    check("tri_sub_count", sub_q.size(), 0);

    // ---- lockout: add held, sub joins, release order, sub re-press ----
    clear_q();
    bus.add_raw = 1'b1;
    t0 = cyc + 1;
    tick(10);
    bus.sub_raw = 1'b1;     // sampled from t0+10, stable at t0+15
    tick(30);
    bus.add_raw = 1'b0;     // sampled low from t0+40
    tick(30);
    bus.sub_raw = 1'b0;     // sampled low from t0+70
    tick(15);
    bus.sub_raw = 1'b1;     // fresh press sampled from t0+85
    tick(10);
    bus.sub_raw = 1'b0;
    tick(20);
    check("lock_add_count", add_q.size(), 1);
    check("lock_add_time", (add_q.size() > 0) ? add_q[0] - t0 : -1, 6);
    check("lock_sub_count", sub_q.size(), 1);
    check("lock_sub_time", (sub_q.size() > 0) ? sub_q[0] - t0 : -1, 91);

    // ---- reset in the middle of a repeat sequence ----
    clear_q();
    bus.add_raw = 1'b1;
    t0 = cyc + 1;
    tick(41);               // just after edge t0+40
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      check($sformatf("rstmid_add_%0d", k),  int'(bus.add_button),  0);
      check($sformatf("rstmid_mode_%0d", k), int'(bus.mode_button), 0);
      tick(1);
    end
    reset = 1'b0;
    t1 = cyc + 1;           // first edge out of reset acts as a new edge 0
    @(negedge clock);
    tick(1);
    @(negedge clock);
    check("rstmid_after_add", int'(bus.add_button), 0);
    tick(31);               // add sampled high on edges t1..t1+31
    bus.add_raw = 1'b0;
    tick(20);
    if (AR) begin
      exp_q = '{t0 + 6, t0 + 26, t0 + 34, t1 + 6, t1 + 26, t1 + 34};
    end else begin
      exp_q = '{t0 + 6, t1 + 6};
    end
    check("rstmid_count", add_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) begin
      check($sformatf("rstmid_pulse_%0d", k), (k < add_q.size()) ? add_q[k] : -1, exp_q[k]);
    end
    check("rstmid_adjacent", adjacent(add_q), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
